// File: rtl/param_shift_register.sv
// param_shift_register: WIDTH-bit register with load, single-step shift/rotate and a multi-position shift engine.
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic             dir,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qp,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir, r_rot, r_sout, r_busy, r_done;
  logic [WIDTH-1:0] r_q;
  logic             w_dir, w_rot, w_in, w_out;
  logic [WIDTH-1:0] w_shifted;
  // single steps use live controls (mode[0] is the direction); the engine uses latched ones
  always_comb begin
    w_dir     = (r_state == SHIFT) ? r_dir : mode[0];
    w_rot     = (r_state == SHIFT) ? r_rot : rotate;
    w_out     = w_dir ? r_q[WIDTH-1] : r_q[0];
    w_in      = w_rot ? w_out : sin;
    w_shifted = w_dir ? {r_q[WIDTH-2:0], w_in} : {w_in, r_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_q     <= RESET_VALUE;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start && amount != '0) begin
          r_dir   <= dir;
          r_rot   <= rotate;
          r_cnt   <= amount;
          r_busy  <= 1'b1;
          r_state <= SHIFT;
        end else if (start) begin
          r_done <= 1'b1;
        end else if (en && mode == 2'b01) begin
          r_q <= D;
        end else if (en && mode[1]) begin
          r_q    <= w_shifted;
          r_sout <= w_out;
        end
      end else begin
        r_q    <= w_shifted;
        r_sout <= w_out;
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end
  assign Q    = r_q;
  assign Qp   = ~r_q;
  assign sout = r_sout;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_param_shift_register.sv
// tb_param_shift_register: directed vector table plus hand sequences for over-width shifts.
module tb_param_shift_register;
  logic       clk = 1'b0;
  logic       rst, en, rotate, sin, start, dir;
  logic [1:0] mode;
  logic [7:0] d;
  logic [3:0] amount;
  logic [7:0] q, qp;
  logic       sout, busy, done;
  int         n_vec = 0;
  int         n_bad = 0;

  param_shift_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rotate(rotate), .sin(sin),
    .D(d), .start(start), .amount(amount), .dir(dir),
    .Q(q), .Qp(qp), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [1:0] mode;
    logic       rot, sin;
    logic [7:0] d;
    logic       start;
    logic [3:0] amt;
    logic       dir;
    logic [7:0] q;
    logic       so, bz, dn;
  } vec_t;

  vec_t vec[28];

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic ro,
                       input logic s, input logic [7:0] dd, input logic st, input logic [3:0] a,
                       input logic dr);
    rst = r; en = e; mode = m; rotate = ro; sin = s; d = dd; start = st; amount = a; dir = dr;
  endtask

  initial begin
    logic [7:0] eq;
    logic       es;
    int         cyc;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
    //         rst   en    mode  rot   sin   D      start amt    dir     Q      sout  busy  done
    vec[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h81, 1'b0, 4'd0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h01, 1'b0, 4'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'hFF, 1'b1, 4'd3, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h33, 1'b1, 4'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1};
    vec[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd4, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};
    vec[15] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'hAA, 1'b1, 4'd2, 1'b0, 8'h84, 1'b0, 1'b1, 1'b0};
    vec[16] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'hAA, 1'b0, 4'd0, 1'b0, 8'h42, 1'b0, 1'b1, 1'b0};
    vec[17] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0};
    vec[18] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h50, 1'b1, 1'b0, 1'b1};
    vec[19] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h50, 1'b1, 1'b0, 1'b0};
    vec[20] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd5, 1'b1, 8'h50, 1'b1, 1'b1, 1'b0};
    vec[21] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0};
    vec[22] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'h43, 1'b1, 1'b1, 1'b0};
    vec[23] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vec[24] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vec[25] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vec[26] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vec[27] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    #2;
    for (int i = 0; i < 28; i++) begin
      drive(vec[i].rst, vec[i].en, vec[i].mode, vec[i].rot, vec[i].sin, vec[i].d,
            vec[i].start, vec[i].amt, vec[i].dir);
      tick();
      chk("Q", i, q, vec[i].q);
      chk("Qp", i, qp, ~vec[i].q);
      chk("sout", i, {7'd0, sout}, {7'd0, vec[i].so});
      chk("busy", i, {7'd0, busy}, {7'd0, vec[i].bz});
      chk("done", i, {7'd0, done}, {7'd0, vec[i].dn});
    end
    // Q=FF, 10 right shifts filling with sin=0
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd10, 1'b0);
    tick();
    chk("ow_start_busy", 0, {7'd0, busy}, 8'd1);
    chk("ow_start_q", 0, q, 8'hFF);
    start = 1'b0;
    eq = 8'hFF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      es = eq[0];
      eq = {1'b0, eq[7:1]};
      chk("ow_q", k, q, eq);
      chk("ow_sout", k, {7'd0, sout}, {7'd0, es});
      chk("ow_busy", k, {7'd0, busy}, (k == 10) ? 8'd0 : 8'd1);
      chk("ow_done", k, {7'd0, done}, (k == 10) ? 8'd1 : 8'd0);
    end
    tick();
    chk("ow_done_after", 11, {7'd0, done}, 8'd0);
    // 9-position right rotate of 81 wraps to a single-step rotate: C0
    drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h81, 1'b0, 4'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b1, 4'd9, 1'b0);
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("rot9_cycles", 0, 8'(cyc), 8'd9);
    chk("rot9_q", 0, q, 8'hC0);
    chk("rot9_sout", 0, {7'd0, sout}, 8'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
